sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
Upstream stage of the traffic-light controller FSM. It conditions the raw vehicle-presence sensor pins (TH, NN, NS) before the FSM consumes them. Per channel it synchronises to the 10 kHz low-frequency clock, debounces, detects arrivals, and holds a sticky request until the FSM acknowledges it. The FSM then sees clean, glitch-free, one-per-arrival demand signals instead of raw pins.

Parameters:
NUM_SENSORS, 3, number of independent sensor channels (bit 0 = TH, 1 = NN, 2 = NS).
DEBOUNCE_TICKS, 200, consecutive clk cycles a synchronised input must differ from the debounced level before the level flips (20 ms at 10 kHz); legal range 1..65535.
STUCK_TICKS, 600000, consecutive high cycles before a channel is flagged stuck (60 s at 10 kHz); used only with the optional feature.

Ports:
clk  input  1  system clock (10 kHz from the low-frequency oscillator).
reset  input  1  asynchronous, active-low reset; all state cleared while low.
enable  input  1  global enable, same source as the FSM/timer enable.
sensor_raw  input  NUM_SENSORS  raw asynchronous sensor pins, active-high = vehicle present.
ack  input  NUM_SENSORS  per-channel request acknowledge from the FSM; one-cycle pulse or level.
sensor_level  output  NUM_SENSORS  debounced presence level.
arrival  output  NUM_SENSORS  one-cycle pulse on each debounced 0->1 transition.
request  output  NUM_SENSORS  sticky demand per channel.
any_request  output  1  OR of request.
stuck  output  NUM_SENSORS  stuck-sensor flags (optional feature; otherwise constant 0).

Behaviour:
- Reset (reset low, asynchronous):
  - Synchroniser flops, debounce counters, sensor_level, arrival, request and stuck are all 0.
  - Release takes effect on the next clk edge.
- Synchroniser:
  - 2-flop chain per channel; sync = second flop.
  - Runs regardless of enable.
- Debounce, per channel, counter width = clog2(DEBOUNCE_TICKS+1):
  - sync == sensor_level: counter <= 0.
  - sync != sensor_level and counter == DEBOUNCE_TICKS-1: sensor_level <= sync; counter <= 0.
  - Otherwise: counter increments.
  - Any single-cycle agreement restarts the count, so glitches shorter than DEBOUNCE_TICKS are rejected.
  - Latency from a clean raw edge to the sensor_level change is exactly 2 + DEBOUNCE_TICKS cycles.
- Enable low:
  - Debounce counters hold their value.
  - sensor_level, arrival and request do not set.
  - ack still clears request.
  - No arrival pulses are generated.
- arrival[i]:
  - Registered; high for exactly one cycle, the cycle after sensor_level[i] rises.
  - Falling edges produce nothing.
- request[i]:
  - Set when arrival[i] is 1.
  - Cleared when ack[i] is 1 and arrival[i] is 0.
  - Simultaneous arrival and ack: the set wins and request stays 1, so a new car is never lost.
  - ack on an idle channel has no effect.
- any_request: combinational OR of request, with no extra latency.
- Channels are fully independent; simultaneous events on different channels are handled in parallel.
- Reset mid-debounce discards partial counts; a sensor held high through reset re-debounces after release and produces one arrival.

Optional Feature:
Macro SENSOR_STUCK_DETECT_EN.
- Defined:
  - A per-channel high-time counter, clog2(STUCK_TICKS+1) bits, increments while sensor_level[i] is 1 and enable is 1, saturating.
  - stuck[i] is set on the cycle the count reaches STUCK_TICKS.
  - While stuck[i] is set, request[i] is forced to 0 and arrival[i] is suppressed, so the FSM stops serving a dead loop.
  - When sensor_level[i] falls, stuck[i] and the counter clear on the next edge.
- Undefined: no counter logic is built; stuck is tied to 0; request behaves as in Behaviour.

Test Plan:
1. Reset low with sensor_raw=3'b111 -> all outputs 0. Release with DEBOUNCE_TICKS=4 -> sensor_level=3'b111 exactly 6 cycles later, arrival=3'b111 for one cycle after that, request=3'b111.
2. Glitch: raw[0] high for 3 cycles, then low (DEBOUNCE_TICKS=4) -> sensor_level[0], arrival[0] and request[0] stay 0.
3. Held request: request[1]=1; ack[1] pulsed 10 cycles later -> request[1]=0 the next cycle; any_request follows.
4. Collision: arrival[2] and ack[2] in the same cycle -> request[2] stays 1. A lone ack[2] later clears it.
5. Enable low: raw[0] rises for 20 cycles -> no arrival and no request. Enable high again -> sensor_level[0] rises after the remaining count and arrival[0] pulses once.
6. With SENSOR_STUCK_DETECT_EN and STUCK_TICKS=16: hold raw[0] high -> stuck[0]=1 and request[0]=0 after 16 high cycles. Drop raw[0] -> stuck[0] clears 2+DEBOUNCE_TICKS+1 cycles after the raw edge.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Conditions raw vehicle-presence pins: 2-flop sync, debounce, arrival pulse, sticky request.
// Optional stuck-sensor detection is built when SENSOR_STUCK_DETECT_EN is defined.
module sensor_conditioner #(
  parameter int NUM_SENSORS    = 3,
  parameter int DEBOUNCE_TICKS = 200,
  parameter int STUCK_TICKS    = 600000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  input  logic [NUM_SENSORS-1:0] ack,
  output logic [NUM_SENSORS-1:0] sensor_level,
  output logic [NUM_SENSORS-1:0] arrival,
  output logic [NUM_SENSORS-1:0] request,
  output logic                   any_request,
  output logic [NUM_SENSORS-1:0] stuck
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [NUM_SENSORS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          level_prev_q;
      logic          arr_q, arr_d;
      logic          req_q, req_d;
      logic          stuck_q, stuck_d;

`ifdef SENSOR_STUCK_DETECT_EN
      localparam int SW = $clog2(STUCK_TICKS + 1);
      localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TICKS);
      logic [SW-1:0] hi_q, hi_d;

      always_comb begin
        hi_d = hi_q;
        if (!level_q)
          hi_d = '0;
        else if (enable && hi_q != STUCK_MAX)
          hi_d = hi_q + SW'(1);
        stuck_d = level_q & (stuck_q | (hi_d == STUCK_MAX));
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hi_q    <= '0;
          stuck_q <= 1'b0;
        end else begin
          hi_q    <= hi_d;
          stuck_q <= stuck_d;
        end
      end
`else
      assign stuck_d = 1'b0;
      assign stuck_q = 1'b0;
`endif

      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        // The whole debouncer freezes while disabled so a partial count survives.
        if (enable) begin
          if (sync2_q[gi] == level_q) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            level_d = sync2_q[gi];
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        arr_d = enable & level_q & ~level_prev_q & ~stuck_q;

        // A fresh arrival beats a same-cycle ack so no car is dropped.
        req_d = req_q;
        if (arr_q) begin
          if (enable) req_d = 1'b1;
        end else if (ack[gi]) begin
          req_d = 1'b0;
        end
        if (stuck_d) req_d = 1'b0;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q        <= '0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          arr_q        <= 1'b0;
          req_q        <= 1'b0;
        end else begin
          cnt_q        <= cnt_d;
          level_q      <= level_d;
          level_prev_q <= level_q;
          arr_q        <= arr_d;
          req_q        <= req_d;
        end
      end

      assign sensor_level[gi] = level_q;
      assign arrival[gi]      = arr_q;
      assign request[gi]      = req_q;
`ifdef SENSOR_STUCK_DETECT_EN
      assign stuck[gi]        = stuck_q;
`else
      // Always 0 for any legal threshold; keeps the parameter referenced.
      assign stuck[gi]        = (STUCK_TICKS < 0);
`endif
    end
  endgenerate

  assign any_request = |request;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: arrival events go through a scoreboard queue
// checked by a monitor; level/request checks are made inline.
module tb_sensor_conditioner;

  localparam int N  = 3;
  localparam int DT = 4;
  localparam int ST = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_raw;
  logic [N-1:0] ack;
  logic [N-1:0] sensor_level, arrival, request, stuck;
  logic         any_request;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  typedef struct {
    int           at_cyc;
    logic [N-1:0] mask;
  } arr_exp_t;
  arr_exp_t exp_q[$];

  sensor_conditioner #(
    .NUM_SENSORS(N), .DEBOUNCE_TICKS(DT), .STUCK_TICKS(ST)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_raw(sensor_raw), .ack(ack),
    .sensor_level(sensor_level), .arrival(arrival), .request(request),
    .any_request(any_request), .stuck(stuck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) begin
      passed++;
      $display("ok   %-16s cyc=%0d value=%0h", name, cyc, act);
    end else begin
      $display("FAIL %-16s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_arrival(input int at_cyc, input logic [N-1:0] mask);
    arr_exp_t e;
    e.at_cyc = at_cyc;
    e.mask   = mask;
    exp_q.push_back(e);
  endtask

  // Monitor: every arrival the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && arrival !== '0) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL arrival_unexp  cyc=%0d actual=%0h required=none", cyc, arrival);
      end else begin
        arr_exp_t e;
        e = exp_q.pop_front();
        check("arrival_mask", 32'(arrival), 32'(e.mask));
        check("arrival_cyc", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog      cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    reset      = 1'b0;
    enable     = 1'b1;
    sensor_raw = 3'b111;
    ack        = '0;

    // 1: reset state, then release with all pins high
    step(3);
    check("rst_level", 32'(sensor_level), 0);
    check("rst_arrival", 32'(arrival), 0);
    check("rst_request", 32'(request), 0);
    check("rst_any", 32'(any_request), 0);
    check("rst_stuck", 32'(stuck), 0);
    c = cyc;
    reset = 1'b1;
    expect_arrival(c + 2 + DT + 1, 3'b111);
    wait_cyc(c + 2 + DT - 1);
    check("lvl_before", 32'(sensor_level), 0);
    wait_cyc(c + 2 + DT);
    check("lvl_rise", 32'(sensor_level), 3'b111);
    wait_cyc(c + 2 + DT + 2);
    check("req_all", 32'(request), 3'b111);
    check("any_all", 32'(any_request), 1);

    // clear everything: pins low, single ack pulse
    sensor_raw = '0;
    ack = 3'b111;
    step(1);
    ack = '0;
    check("req_acked", 32'(request), 0);
    step(10);
    check("lvl_fall", 32'(sensor_level), 0);

    // 2: 3-cycle glitch on channel 0 must be rejected
    sensor_raw = 3'b001;
    step(3);
    sensor_raw = '0;
    step(10);
    check("glitch_lvl", 32'(sensor_level), 0);
    check("glitch_req", 32'(request), 0);

    // 3: held request on channel 1, released by one ack pulse 10 cycles later
    c = cyc;
    sensor_raw = 3'b010;
    expect_arrival(c + 2 + DT + 1, 3'b010);
    wait_cyc(c + 2 + DT + 2);
    check("req1_set", 32'(request), 3'b010);
    step(10);
    check("req1_held", 32'(request), 3'b010);
    check("any_held", 32'(any_request), 1);
    ack = 3'b010;
    step(1);
    ack = '0;
    check("req1_clr", 32'(request), 0);
    check("any_clr", 32'(any_request), 0);
    sensor_raw = '0;
    step(10);

    // 4: ack[2] coincides with arrival[2]; request must still set
    c = cyc;
    sensor_raw = 3'b100;
    expect_arrival(c + 2 + DT + 1, 3'b100);
    wait_cyc(c + 2 + DT + 1);
    ack = 3'b100;
    step(1);
    ack = '0;
    check("collide_req", 32'(request), 3'b100);
    step(3);
    ack = 3'b100;
    step(1);
    ack = '0;
    check("lone_ack", 32'(request), 0);
    sensor_raw = '0;
    step(10);

    // 5: channel 0 rises while disabled; resumes once enable returns
    enable = 1'b0;
    sensor_raw = 3'b001;
    step(20);
    check("dis_lvl", 32'(sensor_level), 0);
    check("dis_req", 32'(request), 0);
    c = cyc;
    enable = 1'b1;
    expect_arrival(c + DT + 1, 3'b001);
    wait_cyc(c + DT - 1);
    check("en_lvl_pre", 32'(sensor_level), 0);
    wait_cyc(c + DT);
    check("en_lvl_rise", 32'(sensor_level), 3'b001);
    wait_cyc(c + DT + 2);
    check("en_req", 32'(request), 3'b001);
    ack = 3'b001;
    step(1);
    ack = '0;
    sensor_raw = '0;
    step(10);

`ifdef SENSOR_STUCK_DETECT_EN
    // 6: channel 0 held high until flagged stuck, then released
    c = cyc;
    sensor_raw = 3'b001;
    expect_arrival(c + 2 + DT + 1, 3'b001);
    wait_cyc(c + 2 + DT + 2);
    check("stk_req_on", 32'(request), 3'b001);
    wait_cyc(c + 2 + DT + ST - 1);
    check("stk_pre", 32'(stuck), 0);
    wait_cyc(c + 2 + DT + ST);
    check("stk_set", 32'(stuck), 3'b001);
    check("stk_req_off", 32'(request), 0);
    c = cyc;
    sensor_raw = '0;
    wait_cyc(c + 2 + DT);
    check("stk_hold", 32'(stuck), 3'b001);
    wait_cyc(c + 2 + DT + 1);
    check("stk_clr", 32'(stuck), 0);
    step(5);
`else
    check("stuck_tied", 32'(stuck), 0);
`endif

    step(3);
    check("sb_pending", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
